// File: rtl/dac_stream_out.sv
// -----------------------------------------------------------------------------
// dac_stream_out
//
// AXI-Stream slave that paces two-channel sample pairs out to the DAC. The
// programmable rate counter generates output ticks. Each tick consumes one
// {B,A} word from a one-entry buffer. The word's two's-complement channels are
// converted to DAC codes and loaded into registered outputs with a
// one-cycle dac_wrt strobe.
//
// A tick with nothing buffered is an underrun. It is counted only once the
// stream has been primed. The outputs then either hold their last code or
// fall back to midscale.
//
// Dropping cfg_enable flushes everything except the underrun counter.
// Only reset clears that counter.
// -----------------------------------------------------------------------------
module dac_stream_out #(
    parameter int DAC_DATA_WIDTH = 14
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic                      cfg_enable,
    input  logic [15:0]               cfg_rate,
    input  logic                      cfg_idle_hold,

    input  logic [31:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,

    output logic [DAC_DATA_WIDTH-1:0] dac_dat_a,
    output logic [DAC_DATA_WIDTH-1:0] dac_dat_b,
    output logic                      dac_wrt,
    output logic [15:0]               underrun_cnt,
    output logic [1:0]                sts_state
);

    localparam int W = DAC_DATA_WIDTH;

    // Code for a signed-zero sample: the DAC's midscale output.
    localparam logic [W-1:0] MID = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_UNDER = 2'd3
    } state_t;

    state_t         state;
    logic [15:0]    cnt;
    logic           tick;
    logic           accept;

    // The buffer holds only the top W bits of each channel.
    // Truncation therefore happens at the stream boundary.
    logic [W-1:0]   buf_a;
    logic [W-1:0]   buf_b;
    logic           buf_full;

    // Converts the top W bits of a two's-complement sample to a DAC code.
    // The sign bit is kept and the magnitude bits are inverted, so zero maps
    // to midscale.
    function automatic logic [W-1:0] to_dac_code(input logic [W-1:0] hi);
        to_dac_code = {hi[W-1], ~hi[W-2:0]};
    endfunction

    // The low-order sample bits below the DAC resolution are discarded by design.
    generate
        if (W < 16) begin : g_trunc
            logic unused_lsbs;
            assign unused_lsbs = ^{s_axis_tdata[31-W:16], s_axis_tdata[15-W:0]};
        end
    endgenerate

    // An output tick fires once the counter reaches the programmed period.
    // The >= comparison lets a shortened period take effect on the next cycle
    // instead of after a full counter wrap.
    assign tick = (state != ST_IDLE) && (cnt >= cfg_rate);

    // NOTE: tready is combinational because a drain on this tick frees the
    // single buffer slot in the same cycle. It depends only on registered state
    // and configuration, never on tvalid, so no combinational loop forms
    // through the AXIS master.
    assign s_axis_tready = (state != ST_IDLE) && (!buf_full || tick);
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign sts_state     = state;

    // Rate counter: free-runs while active and restarts on every tick or when disabled.
    // NOTE: every sequential block uses non-blocking assignments only, so all
    // registers sample the same pre-edge values and the blocks can be read
    // in any order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (!cfg_enable || state == ST_IDLE) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // One-entry sample buffer.
    // A beat accepted on a draining tick replaces the drained sample, so the buffer stays full.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_a    <= '0;
            buf_b    <= '0;
            buf_full <= 1'b0;
        end else if (!cfg_enable || state == ST_IDLE) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_a    <= s_axis_tdata[15:16-W];
            buf_b    <= s_axis_tdata[31:32-W];
            buf_full <= 1'b1;
        end else if (tick) begin
            buf_full <= 1'b0;
        end
    end

    // Sequencing FSM with registered DAC outputs, write strobe and underrun counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            dac_dat_a    <= MID;
            dac_dat_b    <= MID;
            dac_wrt      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            dac_wrt <= 1'b0;

            if (!cfg_enable) begin
                // Disable wins from any state. The underrun history is kept.
                state     <= ST_IDLE;
                dac_dat_a <= MID;
                dac_dat_b <= MID;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_PRIME;
                    end

                    // Waiting for the first sample. Empty ticks here are
                    // expected and are not counted.
                    ST_PRIME: begin
                        if (tick && buf_full) begin
                            dac_dat_a <= to_dac_code(buf_a);
                            dac_dat_b <= to_dac_code(buf_b);
                            dac_wrt   <= 1'b1;
                            state     <= ST_RUN;
                        end
                    end

                    // Streaming. An empty tick is an underrun in either state.
                    ST_RUN, ST_UNDER: begin
                        if (tick) begin
                            if (buf_full) begin
                                dac_dat_a <= to_dac_code(buf_a);
                                dac_dat_b <= to_dac_code(buf_b);
                                dac_wrt   <= 1'b1;
                                state     <= ST_RUN;
                            end else begin
                                state <= ST_UNDER;
                                if (underrun_cnt != 16'hFFFF) begin
                                    underrun_cnt <= underrun_cnt + 16'd1;
                                end
                                if (!cfg_idle_hold) begin
                                    dac_dat_a <= MID;
                                    dac_dat_b <= MID;
                                end
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_stream_out.sv
// -----------------------------------------------------------------------------
// tb_dac_stream_out
//
// Directed, cycle-accurate bench for dac_stream_out with DAC_DATA_WIDTH = 14.
// The stimulus is a linear sequence of steps. Every expected value is a
// hand-computed constant from code = {x[15], ~x[14:2]}, for example:
//   0x7FFF -> 0x0000   0x8000 -> 0x3FFF   0x0000 -> 0x1FFF
//   0x4000 -> 0x0FFF   0xC000 -> 0x2FFF   0x1234 -> 0x1B72
// Inputs change 1 ns after the rising edge.
// Outputs are checked at that point; handshakes are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dac_stream_out;

    localparam int W = 14;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_enable;
    logic [15:0]   cfg_rate;
    logic          cfg_idle_hold;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  dac_dat_a;
    logic [W-1:0]  dac_dat_b;
    logic          dac_wrt;
    logic [15:0]   underrun_cnt;
    logic [1:0]    sts_state;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Source model: beats stream[sidx..stream_limit-1] are offered back to back.
    logic [31:0]   stream [8];
    int            sidx;
    int            stream_limit;

    dac_stream_out #(.DAC_DATA_WIDTH(W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_enable    (cfg_enable),
        .cfg_rate      (cfg_rate),
        .cfg_idle_hold (cfg_idle_hold),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dac_dat_a     (dac_dat_a),
        .dac_dat_b     (dac_dat_b),
        .dac_wrt       (dac_wrt),
        .underrun_cnt  (underrun_cnt),
        .sts_state     (sts_state)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_axis_tvalid = (sidx < stream_limit);
        s_axis_tdata  = (sidx < 8) ? stream[sidx] : 32'h0;
    endtask

    // Advance one clock cycle, tracking the handshake that completes on the edge.
    task automatic step();
        bit hs;
        @(negedge aclk);
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge aclk);
        #1;
        if (hs) sidx++;
        drive();
    endtask

    task automatic disable_and_check(input string tag);
        cfg_enable = 1'b0;
        step();
        check({tag, "_state"},  32'(sts_state), 32'd0);
        check({tag, "_dat_a"},  32'(dac_dat_a), 32'h1FFF);
        check({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    endtask

    // Two beats, three empty ticks at cfg_rate = 1, then one more beat.
    // base is the underrun count before the run.
    task automatic run_underrun(input bit hold, input logic [15:0] base, input string tag);
        logic [31:0] held_a;
        logic [31:0] held_b;
        held_a        = hold ? 32'h2FFF : 32'h1FFF;
        held_b        = hold ? 32'h3FFF : 32'h1FFF;
        cfg_rate      = 16'd1;
        cfg_idle_hold = hold;
        stream[0]     = 32'h1234_4000;
        stream[1]     = 32'h8000_C000;
        stream[2]     = 32'h0000_7FFF;
        sidx          = 0;
        stream_limit  = 2;
        cfg_enable    = 1'b1;
        drive();
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 11) begin
                stream_limit = 3;
                drive();
            end
            if (k == 3) begin
                check({tag, "_wrt_first"},  32'(dac_wrt),   32'd1);
                check({tag, "_a_first"},    32'(dac_dat_a), 32'h0FFF);
                check({tag, "_b_first"},    32'(dac_dat_b), 32'h1B72);
            end
            if (k == 5) begin
                check({tag, "_wrt_second"}, 32'(dac_wrt),   32'd1);
                check({tag, "_a_second"},   32'(dac_dat_a), 32'h2FFF);
                check({tag, "_b_second"},   32'(dac_dat_b), 32'h3FFF);
                check({tag, "_state_run"},  32'(sts_state), 32'd2);
            end
            if (k == 7) begin
                check({tag, "_state_under"}, 32'(sts_state),    32'd3);
                check({tag, "_under_1"},     32'(underrun_cnt), 32'(base + 16'd1));
                check({tag, "_wrt_empty"},   32'(dac_wrt),      32'd0);
                check({tag, "_a_empty"},     32'(dac_dat_a),    held_a);
                check({tag, "_b_empty"},     32'(dac_dat_b),    held_b);
            end
            if (k == 11) begin
                check({tag, "_state_under3"}, 32'(sts_state),    32'd3);
                check({tag, "_under_3"},      32'(underrun_cnt), 32'(base + 16'd3));
                check({tag, "_a_empty3"},     32'(dac_dat_a),    held_a);
            end
            if (k == 13) begin
                check({tag, "_state_resume"}, 32'(sts_state),    32'd2);
                check({tag, "_wrt_resume"},   32'(dac_wrt),      32'd1);
                check({tag, "_a_resume"},     32'(dac_dat_a),    32'h0000);
                check({tag, "_b_resume"},     32'(dac_dat_b),    32'h1FFF);
                check({tag, "_under_final"},  32'(underrun_cnt), 32'(base + 16'd3));
            end
        end
        disable_and_check({tag, "_off"});
    endtask

    initial begin
        logic [31:0] exp_a [6];
        bit          wrt_seen;

        // ---- Reset, disabled, source offering data ------------------------
        aresetn       = 1'b0;
        cfg_enable    = 1'b0;
        cfg_rate      = 16'd0;
        cfg_idle_hold = 1'b1;
        stream[0]     = 32'h0000_7FFF;
        sidx          = 0;
        stream_limit  = 1;
        drive();
        repeat (2) @(posedge aclk);
        #1;
        check("rst_dat_a",  32'(dac_dat_a),     32'h1FFF);
        check("rst_dat_b",  32'(dac_dat_b),     32'h1FFF);
        check("rst_wrt",    32'(dac_wrt),       32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_state",  32'(sts_state),     32'd0);
        check("rst_under",  32'(underrun_cnt),  32'd0);
        aresetn  = 1'b1;
        wrt_seen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("dis_tready_%0d", k), 32'(s_axis_tready), 32'd0);
            wrt_seen |= dac_wrt;
        end
        check("dis_dat_a",    32'(dac_dat_a), 32'h1FFF);
        check("dis_wrt_seen", 32'(wrt_seen),  32'd0);

        // ---- cfg_rate = 3: one sample every 4 cycles, conversion extremes --
        cfg_rate     = 16'd3;
        stream[0]    = 32'h8000_7FFF;
        stream[1]    = 32'h7FFF_8000;
        stream[2]    = 32'h1234_0000;
        sidx         = 0;
        stream_limit = 3;
        cfg_enable   = 1'b1;
        drive();
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("r3_wrt_%0d", k), 32'(dac_wrt), (k == 5 || k == 9 || k == 13) ? 32'd1 : 32'd0);
            if (k == 1) check("r3_state_prime", 32'(sts_state), 32'd1);
            if (k == 5) begin
                check("r3_a_7fff", 32'(dac_dat_a), 32'h0000);
                check("r3_b_8000", 32'(dac_dat_b), 32'h3FFF);
                check("r3_state_run", 32'(sts_state), 32'd2);
            end
            if (k == 9) begin
                check("r3_a_8000", 32'(dac_dat_a), 32'h3FFF);
                check("r3_b_7fff", 32'(dac_dat_b), 32'h0000);
            end
            if (k == 13) begin
                check("r3_a_0000", 32'(dac_dat_a), 32'h1FFF);
                check("r3_b_1234", 32'(dac_dat_b), 32'h1B72);
            end
        end
        disable_and_check("r3_off");
        check("r3_under", 32'(underrun_cnt), 32'd0);

        // ---- cfg_rate = 0: one sample per cycle, 1-cycle latency ----------
        cfg_rate     = 16'd0;
        stream[0]    = 32'h0000_0000;
        stream[1]    = 32'h0000_4000;
        stream[2]    = 32'h0000_C000;
        stream[3]    = 32'h0000_7FFF;
        stream[4]    = 32'h0000_8000;
        stream[5]    = 32'h0000_1234;
        exp_a[0]     = 32'h1FFF;
        exp_a[1]     = 32'h0FFF;
        exp_a[2]     = 32'h2FFF;
        exp_a[3]     = 32'h0000;
        exp_a[4]     = 32'h3FFF;
        exp_a[5]     = 32'h1B72;
        sidx         = 0;
        stream_limit = 6;
        cfg_enable   = 1'b1;
        drive();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k <= 7) check($sformatf("r0_tready_%0d", k), 32'(s_axis_tready), 32'd1);
            check($sformatf("r0_wrt_%0d", k), 32'(dac_wrt), (k >= 3) ? 32'd1 : 32'd0);
            if (k >= 3) check($sformatf("r0_a_%0d", k), 32'(dac_dat_a), exp_a[k-3]);
        end
        check("r0_b",     32'(dac_dat_b),    32'h1FFF);
        check("r0_under", 32'(underrun_cnt), 32'd0);
        disable_and_check("r0_off");
        check("r0_under_off", 32'(underrun_cnt), 32'd0);

        // ---- Underrun with hold, then with midscale -----------------------
        run_underrun(1'b1, 16'd0, "hold");
        run_underrun(1'b0, 16'd3, "mid");

        // ---- Disable in RUN with a full buffer, then re-prime -------------
        cfg_rate      = 16'd3;
        cfg_idle_hold = 1'b1;
        stream[0]     = 32'h0000_7FFF;
        stream[1]     = 32'h0000_8000;
        stream[2]     = 32'h0000_0000;
        sidx          = 0;
        stream_limit  = 3;
        cfg_enable    = 1'b1;
        drive();
        repeat (5) step();
        check("drop_wrt",   32'(dac_wrt),   32'd1);
        check("drop_state", 32'(sts_state), 32'd2);
        check("drop_a",     32'(dac_dat_a), 32'h0000);
        stream_limit = sidx;
        drive();
        disable_and_check("drop_off");
        check("drop_off_b",   32'(dac_dat_b), 32'h1FFF);
        check("drop_off_wrt", 32'(dac_wrt),   32'd0);
        cfg_enable = 1'b1;
        wrt_seen   = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("reprime_state_%0d", k), 32'(sts_state), 32'd1);
            wrt_seen |= dac_wrt;
        end
        check("reprime_wrt_seen", 32'(wrt_seen),     32'd0);
        check("reprime_under",    32'(underrun_cnt), 32'd6);
        check("reprime_a",        32'(dac_dat_a),    32'h1FFF);

        // ---- Asynchronous reset mid-cycle ----------------------------------
        stream[0]    = 32'h0000_4000;
        sidx         = 0;
        stream_limit = 1;
        drive();
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_under",  32'(underrun_cnt),  32'd0);
        check("arst_state",  32'(sts_state),     32'd0);
        check("arst_a",      32'(dac_dat_a),     32'h1FFF);
        check("arst_tready", 32'(s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        step();
        check("arst_release_state", 32'(sts_state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
